aes_key_schedule: RTL

- Parametrised AES key-expansion engine supporting AES-128, AES-192 and AES-256 from one RTL source.
- Accepts a cipher key and generates all round-key words, one word per clock, into an internal word store.
- Serves 128-bit round keys to the CTR-mode cipher core through a registered read port.
- Successor to the fixed 256-bit expansion FSM: parametrised key size, start/done handshake, random-access round-key read, re-keying, and error flagging.

---
 rtl/aes_key_schedule.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_schedule.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | aes_key_schedule : AES-128/192/256 key expansion, one word per clock,  |
// |                    with a registered random-access round-key port.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module aes_key_schedule #(
   parameter int KEY_BITS = 256,
   parameter int IDX_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [KEY_BITS-1:0] key_in,
   output logic                busy,
   output logic                done,
   output logic                key_valid,
   input  logic                rk_req,
   input  logic [IDX_W-1:0]    rk_idx,
   output logic                rk_valid,
   output logic [127:0]        rk_data,
   output logic                rk_err
);

   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam int AW = $clog2(NW);

   localparam logic [AW-1:0]    LAST_W   = AW'(NW - 1);
   localparam logic [AW-1:0]    NK_W     = AW'(NK);
   localparam logic [AW-1:0]    MOD_LAST = AW'(NK - 1);
   localparam logic [AW-1:0]    MOD_SUB  = AW'(4);
   localparam logic [IDX_W-1:0] NR_IDX   = IDX_W'(NR);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte of the table, hence the inverted index.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_EXPAND = 2'd2,
      S_READY  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            key_valid_q, key_valid_d;
   logic [AW-1:0]   i_q, i_d;
   logic [AW-1:0]   mod_q, mod_d;
   logic [7:0]      rcon_q, rcon_d;
   logic [31:0]     win_q [NK];
   logic [31:0]     win_d [NK];
   logic            rk_valid_q, rk_valid_d;
   logic            rk_err_q, rk_err_d;
   logic [127:0]    rk_data_q, rk_data_d;

   logic            start_ok;
   logic            load_en;
   logic            exp_en;
   logic [31:0]     t_word;
   logic [31:0]     new_word;
   logic [AW-1:0]   rd_base;
   logic            rd_legal;
   logic [31:0]     word_mem [NW];

   assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_READY));

   // win_q holds the last NK words: win_q[0] = w[i-NK], win_q[NK-1] = w[i-1].
   always_comb begin
      t_word = win_q[NK-1];
      if (mod_q == '0) begin
         t_word = sub_word({win_q[NK-1][23:0], win_q[NK-1][31:24]}) ^ {rcon_q, 24'h0};
      end else if ((NK == 8) && (mod_q == MOD_SUB)) begin
         t_word = sub_word(win_q[NK-1]);
      end
      new_word = win_q[0] ^ t_word;
   end

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      key_valid_d = key_valid_q;
      i_d         = i_q;
      mod_d       = mod_q;
      rcon_d      = rcon_q;
      load_en     = 1'b0;
      exp_en      = 1'b0;
      case (state_q)
         S_IDLE, S_READY: begin
            if (start_ok) begin
               state_d     = S_LOAD;
               busy_d      = 1'b1;
               key_valid_d = 1'b0;
            end
         end
         S_LOAD: begin
            load_en = 1'b1;
            i_d     = NK_W;
            mod_d   = '0;
            rcon_d  = 8'h01;
            state_d = S_EXPAND;
         end
         S_EXPAND: begin
            exp_en = 1'b1;
            i_d    = i_q + AW'(1);
            mod_d  = (mod_q == MOD_LAST) ? '0 : mod_q + AW'(1);
            if (mod_q == '0) begin
               rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
            if (i_q == LAST_W) begin
               state_d     = S_READY;
               busy_d      = 1'b0;
               key_valid_d = 1'b1;
               done_d      = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      for (int k = 0; k < NK; k++) begin
         win_d[k] = win_q[k];
      end
      if (load_en) begin
         for (int k = 0; k < NK; k++) begin
            win_d[k] = key_in[KEY_BITS-1-32*k -: 32];
         end
      end else if (exp_en) begin
         for (int k = 0; k < NK - 1; k++) begin
            win_d[k] = win_q[k+1];
         end
         win_d[NK-1] = new_word;
      end
   end

   // A read coinciding with an accepted start already sees the schedule as gone.
   assign rd_base  = AW'({rk_idx, 2'b00});
   assign rd_legal = key_valid_q && !start_ok && (rk_idx <= NR_IDX);

   always_comb begin
      rk_valid_d = rk_req;
      rk_err_d   = 1'b0;
      rk_data_d  = rk_data_q;
      if (rk_req) begin
         if (rd_legal) begin
            rk_data_d = {word_mem[rd_base],          word_mem[rd_base + AW'(1)],
                         word_mem[rd_base + AW'(2)], word_mem[rd_base + AW'(3)]};
         end else begin
            rk_data_d = '0;
            rk_err_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         key_valid_q <= 1'b0;
         i_q         <= '0;
         mod_q       <= '0;
         rcon_q      <= 8'h01;
         for (int k = 0; k < NK; k++) begin
            win_q[k] <= '0;
         end
         rk_valid_q  <= 1'b0;
         rk_err_q    <= 1'b0;
         rk_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         key_valid_q <= key_valid_d;
         i_q         <= i_d;
         mod_q       <= mod_d;
         rcon_q      <= rcon_d;
         for (int k = 0; k < NK; k++) begin
            win_q[k] <= win_d[k];
         end
         rk_valid_q  <= rk_valid_d;
         rk_err_q    <= rk_err_d;
         rk_data_q   <= rk_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (load_en) begin
         for (int k = 0; k < NK; k++) begin
            word_mem[k] <= key_in[KEY_BITS-1-32*k -: 32];
         end
      end else if (exp_en) begin
         word_mem[i_q] <= new_word;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign key_valid = key_valid_q;
   assign rk_valid  = rk_valid_q;
   assign rk_err    = rk_err_q;
   assign rk_data   = rk_data_q;

endmodule
`default_nettype wire
